serial_operand_serializer: RTL and testbench

- Transmit end of the bit-serial compare link. Accepts a parallel operand pair (a_in, b_in) over a valid/ready handshake and emits it MSB-first as paired bits (a_bit, b_bit), one pair per accepted beat.
- Framing is carried on bit_first and bit_last.
- The downstream bit-serial comparator asserts stop_in once the result is decided (first differing bit). The serializer then drops the remaining bits of that word.
- Sits between the operand source and the serial comparator core.

---
 rtl/serial_operand_serializer_pkg.sv | 17 +
 rtl/serial_operand_serializer_shift_reg.sv | 27 ++
 rtl/serial_operand_serializer.sv | 125 ++++++++++++
 tb/tb_serial_operand_serializer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/serial_operand_serializer_pkg.sv
// Shared definitions for the bit-serial compare link: FSM encoding, counter
// widths and the bit-counter width derivation used by both link ends.
package serial_operand_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int WORDS_CNT_W = 8;

  // Bit-counter width for a given operand width; never narrower than 1 bit.
  function automatic int calc_cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_operand_serializer_shift_reg.sv
// Parallel-load, shift-left register presenting its MSB; one per operand.
module operand_shift_reg #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [width-1:0] data_i,
  output logic             msb_o
);

  logic [width-1:0] sr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= data_i;
    end else if (shift_i) begin
      sr_q <= sr_q << 1;
    end
  end

  assign msb_o = sr_q[width-1];

endmodule

// File: rtl/serial_operand_serializer.sv
// Transmit end of the bit-serial compare link: takes an operand pair and
// emits it MSB-first as framed bit pairs, aborting early on downstream stop.
module serial_operand_serializer
  import serial_operand_serializer_pkg::*;
#(
  parameter int width = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [width-1:0]       a_in,
  input  logic [width-1:0]       b_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   a_bit,
  output logic                   b_bit,
  output logic                   bit_valid,
  input  logic                   bit_ready,
  output logic                   bit_first,
  output logic                   bit_last,
  input  logic                   stop_in,
  output logic                   word_done,
  output logic                   word_stopped,
  output logic [WORDS_CNT_W-1:0] words_cnt
);

  localparam int cnt_w = calc_cnt_w(width);

  state_e                 state_q, state_d;
  logic [cnt_w-1:0]       cnt_q, cnt_d;
  logic                   first_q, first_d;
  logic                   last_q, last_d;
  logic                   done_q, done_d;
  logic                   stopped_q, stopped_d;
  logic [WORDS_CNT_W-1:0] words_q, words_d;
  logic                   load, shift;

  operand_shift_reg #(.width(width)) u_sr_a (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (a_in),
    .msb_o   (a_bit)
  );

  operand_shift_reg #(.width(width)) u_sr_b (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (b_in),
    .msb_o   (b_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      stopped_q <= 1'b0;
      words_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      last_q    <= last_d;
      done_q    <= done_d;
      stopped_q <= stopped_d;
      words_q   <= words_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    last_d    = last_q;
    done_d    = 1'b0;
    stopped_d = 1'b0;
    words_d   = words_q;
    load      = 1'b0;
    shift     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          cnt_d   = cnt_w'(width - 1);
          first_d = 1'b1;
          last_d  = (width == 1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // stop_in only matters on an actual transfer; stalls hold everything.
        if (bit_ready) begin
          if (last_q || stop_in) begin
            state_d   = ST_IDLE;
            first_d   = 1'b0;
            last_d    = 1'b0;
            done_d    = 1'b1;
            stopped_d = stop_in & ~last_q;
            words_d   = words_q + WORDS_CNT_W'(1);
          end else begin
            shift   = 1'b1;
            cnt_d   = cnt_q - cnt_w'(1);
            first_d = 1'b0;
            last_d  = (cnt_q == cnt_w'(1));
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready     = (state_q == ST_IDLE);
  assign bit_valid    = (state_q == ST_SHIFT);
  assign bit_first    = first_q;
  assign bit_last     = last_q;
  assign word_done    = done_q;
  assign word_stopped = stopped_q;
  assign words_cnt    = words_q;

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Directed bench for serial_operand_serializer (width=4): table of words plus
// backpressure, wrap and mid-word reset sequences.
module tb_serial_operand_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] a_in, b_in;
  logic       in_valid, in_ready;
  logic       a_bit, b_bit, bit_valid, bit_ready;
  logic       bit_first, bit_last, stop_in;
  logic       word_done, word_stopped;
  logic [7:0] words_cnt;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_words = 8'd0;

  serial_operand_serializer #(.width(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .a_in         (a_in),
    .b_in         (b_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a_bit        (a_bit),
    .b_bit        (b_bit),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready),
    .bit_first    (bit_first),
    .bit_last     (bit_last),
    .stop_in      (stop_in),
    .word_done    (word_done),
    .word_stopped (word_stopped),
    .words_cnt    (words_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] stop_mask;   // bit i: stop_in asserted on transfer of pair i
    int         exp_n;       // pairs transferred before the word ends
    logic       exp_stopped;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " in_ready"},     32'(in_ready),     32'd1);
    chk({tag, " bit_valid"},    32'(bit_valid),    32'd0);
    chk({tag, " a_bit"},        32'(a_bit),        32'd0);
    chk({tag, " b_bit"},        32'(b_bit),        32'd0);
    chk({tag, " bit_first"},    32'(bit_first),    32'd0);
    chk({tag, " bit_last"},     32'(bit_last),     32'd0);
    chk({tag, " word_done"},    32'(word_done),    32'd0);
    chk({tag, " word_stopped"}, 32'(word_stopped), 32'd0);
    chk({tag, " words_cnt"},    32'(words_cnt),    32'd0);
  endtask

  // Called at posedge+1 with the DUT idle; bit_ready held high.
  task automatic run_word(input vec_t v, input string tag);
    a_in = v.a; b_in = v.b; in_valid = 1'b1; stop_in = 1'b0; bit_ready = 1'b1;
    chk({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s bit_valid p%0d", tag, i), 32'(bit_valid), 32'd1);
      chk($sformatf("%s in_ready p%0d", tag, i),  32'(in_ready),  32'd0);
      chk($sformatf("%s a_bit p%0d", tag, i),     32'(a_bit),     32'(v.a[3-i]));
      chk($sformatf("%s b_bit p%0d", tag, i),     32'(b_bit),     32'(v.b[3-i]));
      chk($sformatf("%s first p%0d", tag, i),     32'(bit_first), 32'(i == 0));
      chk($sformatf("%s last p%0d", tag, i),      32'(bit_last),  32'(i == 3));
      stop_in = v.stop_mask[i];
      step();
      stop_in = 1'b0;
      if (i == v.exp_n - 1) break;
      chk($sformatf("%s no done p%0d", tag, i), 32'(word_done), 32'd0);
    end
    exp_words = exp_words + 8'd1;
    chk({tag, " word_done"},    32'(word_done),    32'd1);
    chk({tag, " word_stopped"}, 32'(word_stopped), 32'(v.exp_stopped));
    chk({tag, " bit_valid end"}, 32'(bit_valid),   32'd0);
    chk({tag, " in_ready end"}, 32'(in_ready),     32'd1);
    chk({tag, " first end"},    32'(bit_first),    32'd0);
    chk({tag, " last end"},     32'(bit_last),     32'd0);
    chk({tag, " words_cnt"},    32'(words_cnt),    32'(exp_words));
    step();
    chk({tag, " done pulse"},    32'(word_done),    32'd0);
    chk({tag, " stopped pulse"}, 32'(word_stopped), 32'd0);
  endtask

  initial begin
    int         p, cycles, dones;
    logic [6:0] rdy_pat;
    logic [3:0] bp_a;

    vecs[0] = '{a: 4'hA, b: 4'hB, stop_mask: 4'b0000, exp_n: 4, exp_stopped: 1'b0};
    vecs[1] = '{a: 4'h8, b: 4'h0, stop_mask: 4'b0001, exp_n: 1, exp_stopped: 1'b1};
    vecs[2] = '{a: 4'h1, b: 4'h0, stop_mask: 4'b1000, exp_n: 4, exp_stopped: 1'b0};
    vecs[3] = '{a: 4'hC, b: 4'h3, stop_mask: 4'b0010, exp_n: 2, exp_stopped: 1'b1};
    vecs[4] = '{a: 4'hF, b: 4'hF, stop_mask: 4'b0000, exp_n: 4, exp_stopped: 1'b0};

    reset = 1'b1; a_in = '0; b_in = '0; in_valid = 1'b0; bit_ready = 1'b0; stop_in = 1'b0;
    #12;
    chk_reset_vals("por");
    @(negedge clk);
    reset = 1'b0;
    step();

    for (int k = 0; k < 5; k++) run_word(vecs[k], $sformatf("vec%0d", k));

    // Backpressure: stop_in high during stalls must be ignored.
    bp_a    = 4'h5;
    rdy_pat = 7'b1011001;  // applied LSB first: 1,0,0,1,1,0,1
    a_in = bp_a; b_in = bp_a; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    p = 0;
    for (int c = 0; c < 7; c++) begin
      chk($sformatf("bp valid c%0d", c), 32'(bit_valid), 32'd1);
      chk($sformatf("bp a_bit c%0d", c), 32'(a_bit),     32'(bp_a[3-p]));
      chk($sformatf("bp b_bit c%0d", c), 32'(b_bit),     32'(bp_a[3-p]));
      chk($sformatf("bp first c%0d", c), 32'(bit_first), 32'(p == 0));
      chk($sformatf("bp last c%0d", c),  32'(bit_last),  32'(p == 3));
      bit_ready = rdy_pat[c];
      stop_in   = ~rdy_pat[c];
      step();
      stop_in = 1'b0;
      if (rdy_pat[c]) p++;
    end
    exp_words = exp_words + 8'd1;
    chk("bp word_done",    32'(word_done),    32'd1);
    chk("bp word_stopped", 32'(word_stopped), 32'd0);
    chk("bp words_cnt",    32'(words_cnt),    32'(exp_words));
    bit_ready = 1'b1;
    step();

    // Wrap: 256 back-to-back words from a clean counter.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    step();
    exp_words = 8'd0;
    a_in = 4'h3; b_in = 4'h6; in_valid = 1'b1; bit_ready = 1'b1;
    cycles = 0; dones = 0;
    while (dones < 256 && cycles < 1400) begin
      step();
      cycles++;
      if (word_done) begin
        dones++;
        if (dones == 255) chk("wrap cnt 255", 32'(words_cnt), 32'd255);
      end
    end
    in_valid = 1'b0;
    chk("wrap dones",  32'(dones),     32'd256);
    chk("wrap cycles", 32'(cycles),    32'd1280);
    chk("wrap cnt 0",  32'(words_cnt), 32'd0);
    step();

    run_word(vecs[0], "pre_rst");

    // Mid-word reset while pair 2 is presented.
    a_in = 4'hA; b_in = 4'hB; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("mw pair2 a_bit", 32'(a_bit), 32'd1);
    chk("mw pair2 first", 32'(bit_first), 32'd0);
    #2 reset = 1'b1;
    #1 chk_reset_vals("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    exp_words = 8'd0;
    step();
    chk("mw no done 1", 32'(word_done), 32'd0);
    step();
    chk("mw no done 2", 32'(word_done), 32'd0);
    run_word(vecs[0], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
